// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with a post-reset clear sequencer and registered, valid-qualified reads.
// Optional build macro RAM_RDW_BYPASS_EN: write-first bypass on same-cycle, same-address write/read.
module ram_dp_clr #(
  parameter int unsigned             DATA_WIDTH  = 4,
  parameter int unsigned             ADDR_WIDTH  = 8,
  parameter int unsigned             RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_n,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_hit, rd_hit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
  assign busy        = (state == CLEAR);

  // The clear sequencer and the user write port share the single memory write port.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt;
    mem_wdata = CLEAR_VALUE;
    wr_hit    = 1'b0;
    rd_hit    = 1'b0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (clr_cnt == LAST) state_nxt = READY;
      end
      READY: begin
        wr_hit    = !wr_n && wr_in_range;
        rd_hit    = rd_en;
        mem_we    = wr_hit;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_hit;
      // Counter parks on the last location so it never wraps.
      if (state == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
      if (rd_hit) begin
`ifdef RAM_RDW_BYPASS_EN
        if (wr_hit && wr_addr == rd_addr)
          rd_data <= wr_data;
        else
`endif
        rd_data <= rd_in_range ? mem[rd_addr] : CLEAR_VALUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
